// File: rtl/snake_dir_ctrl_pkg.sv
// ============================================================================
// Module : snake_dir_ctrl_pkg
// Brief  : Shared direction encodings, queue depth and helpers for the
//          snake direction controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package snake_dir_ctrl_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_LEFT  = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_UP    = 2'd2;
    localparam dir_t DIR_DOWN  = 2'd3;

    localparam int QUEUE_DEPTH = 2;

    // Encodings pair up so that the opposite differs only in bit 0.
    function automatic dir_t opposite_dir(input dir_t d);
        return {d[1], ~d[0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/snake_dir_ctrl_btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : 2-FF synchroniser, counter debouncer and registered press edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import snake_dir_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            // Any return to the current level restarts qualification.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/snake_dir_ctrl.sv
// ============================================================================
// Module : snake_dir_ctrl
// Brief  : Button conditioning, turn validation, 2-deep turn queue and
//          tick-paced direction commit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module snake_dir_ctrl
    import snake_dir_ctrl_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter int         CNT_W           = 20,
    parameter logic [1:0] INIT_DIR        = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnu,
    input  logic       btnd,
    input  logic       btnl,
    input  logic       btnr,
    input  logic       tick,
    input  logic       clear,
    output logic [1:0] direction,
    output logic [1:0] pending,
    output logic       turn_accepted,
    output logic       turn_dropped
);

    localparam logic [1:0] C_FULL = 2'(QUEUE_DEPTH);

    // Index order doubles as press priority: r, l, u, d.
    logic [3:0] w_raw;
    logic [3:0] w_press;
    logic [3:0] w_unused_level;

    assign w_raw = {btnd, btnu, btnl, btnr};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_btn_debounce (
                .clk   (clk),
                .rst   (rst),
                .raw   (w_raw[gi]),
                .level (w_unused_level[gi]),
                .press (w_press[gi])
            );
        end
    endgenerate

    dir_t       r_dir;
    dir_t       r_q0;
    dir_t       r_q1;
    logic [1:0] r_count;
    logic       r_accepted;
    logic       r_dropped;

    dir_t       w_cand;
    dir_t       w_ref;
    logic       w_have;
    logic       w_valid;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    dir_t       w_dir;
    dir_t       w_q0;
    dir_t       w_q1;
    logic [1:0] w_cnt;

    always_comb begin
        w_have = |w_press;
        if (w_press[0])      w_cand = DIR_RIGHT;
        else if (w_press[1]) w_cand = DIR_LEFT;
        else if (w_press[2]) w_cand = DIR_UP;
        else                 w_cand = DIR_DOWN;

        if (r_count == 2'd2)      w_ref = r_q1;
        else if (r_count == 2'd1) w_ref = r_q0;
        else                      w_ref = r_dir;

        // A full queue can still take a turn if this tick frees a slot.
        w_valid = (w_cand != w_ref) && (w_cand != opposite_dir(w_ref))
                  && !((r_count == C_FULL) && !tick);
        w_pop   = tick && (r_count != 2'd0);
        w_push  = w_have && w_valid;
        w_drop  = w_have && !w_valid;

        w_dir = r_dir;
        w_q0  = r_q0;
        w_q1  = r_q1;
        w_cnt = r_count;
        if (w_pop) begin
            w_dir = r_q0;
            w_q0  = r_q1;
            w_cnt = r_count - 2'd1;
        end
        if (w_push) begin
            if (w_cnt == 2'd0) w_q0 = w_cand;
            else               w_q1 = w_cand;
            w_cnt = w_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dir      <= INIT_DIR;
            r_q0       <= INIT_DIR;
            r_q1       <= INIT_DIR;
            r_count    <= 2'd0;
            r_accepted <= 1'b0;
            r_dropped  <= 1'b0;
        end else if (clear) begin
            r_dir      <= INIT_DIR;
            r_count    <= 2'd0;
            r_accepted <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_dir      <= w_dir;
            r_q0       <= w_q0;
            r_q1       <= w_q1;
            r_count    <= w_cnt;
            r_accepted <= w_push;
            r_dropped  <= w_drop;
        end
    end

    assign direction     = r_dir;
    assign pending       = r_count;
    assign turn_accepted = r_accepted;
    assign turn_dropped  = r_dropped;

endmodule

`default_nettype wire
